// File: rtl/fifo_frame_reader_pkg.sv
// Shared definitions for the audio FIFO frame reader: FSM encoding and
// standard frame lengths for the FFT front end.
package fifo_frame_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int unsigned FRAME_LEN_FFT256  = 256;
   localparam int unsigned FRAME_LEN_FFT512  = 512;
   localparam int unsigned FRAME_LEN_FFT1024 = 1024;
   localparam int unsigned DEFAULT_FRAME_LEN = FRAME_LEN_FFT1024;

endpackage

// File: rtl/fifo_frame_reader_if.sv
// FIFO read port plus framed valid/ready stream of the frame reader.
// master is the reader's view, slave is the FIFO/downstream side.
interface fifo_frame_reader_if #(
   parameter int unsigned DATA_WIDTH = 16
);
   logic                  fifo_rd_en;
   logic [DATA_WIDTH-1:0] fifo_rd_data;
   logic                  fifo_empty;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_last;

   modport master (
      output fifo_rd_en, m_valid, m_data, m_last,
      input  fifo_rd_data, fifo_empty, m_ready
   );

   modport slave (
      input  fifo_rd_en, m_valid, m_data, m_last,
      output fifo_rd_data, fifo_empty, m_ready
   );
endinterface

// File: rtl/fifo_frame_reader_skid_buf.sv
// Two-entry FIFO-ordered register buffer; head entry drives the output.
module frame_skid_buf #(
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  pop,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] dout,
   output logic [1:0]            occ
);
   logic [DATA_WIDTH-1:0] head;
   logic [DATA_WIDTH-1:0] tail;

   // pop is only ever asserted with valid=1, and push never arrives when full
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) head <= din;
               else             tail <= din;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               head <= tail;
               occ  <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  head <= din;
               end else begin
                  head <= tail;
                  tail <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign valid = (occ != 2'd0);
   assign dout  = head;
endmodule

// File: rtl/fifo_frame_reader.sv
// Drains the audio FIFO and re-emits samples as FRAME_LEN-sample frames
// with a last marker; starts and stops only on frame boundaries.
module fifo_frame_reader
   import fifo_frame_reader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned FRAME_LEN     = DEFAULT_FRAME_LEN,
   parameter int unsigned CNT_WIDTH     = 16,
   parameter int unsigned FRM_CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   fifo_frame_reader_if.master      bus,
   output logic [FRM_CNT_WIDTH-1:0] frame_cnt,
   output logic                     busy
);
   localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(FRAME_LEN - 1);

   state_t                state, state_nxt;
   logic [CNT_WIDTH-1:0]  rd_cnt;
   logic [CNT_WIDTH-1:0]  out_cnt;
   logic                  inflight;
   logic                  rd_en;
   logic                  last_rd;
   logic                  handshake;
   logic                  sk_valid;
   logic [DATA_WIDTH-1:0] sk_data;
   logic [1:0]            occ;
   logic [2:0]            level;

   frame_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
      .clk   (clk),
      .rst   (rst),
      .push  (inflight),
      .din   (bus.fifo_rd_data),
      .pop   (handshake),
      .valid (sk_valid),
      .dout  (sk_data),
      .occ   (occ)
   );

   assign handshake    = sk_valid && bus.m_ready;
   assign bus.m_valid  = sk_valid;
   assign bus.m_data   = sk_data;
   assign bus.m_last   = sk_valid && (out_cnt == LAST_IDX);
   assign bus.fifo_rd_en = rd_en;

   // Buffer level after this cycle's edge; a beat leaving now frees its slot,
   // which keeps reads back to back under full throughput (handshake implies occ>=1).
   assign level = {1'b0, occ} + {2'b00, inflight} - {2'b00, handshake};

   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      last_rd   = 1'b0;
      busy      = (state != ST_IDLE);
      case (state)
         ST_IDLE: begin
            if (en) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            rd_en   = !bus.fifo_empty && (level < 3'd2);
            last_rd = rd_en && (rd_cnt == LAST_IDX);
            if (last_rd && !en) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if ((occ == 2'd0) && !inflight) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         inflight  <= 1'b0;
         rd_cnt    <= '0;
         out_cnt   <= '0;
         frame_cnt <= '0;
      end else begin
         state    <= state_nxt;
         inflight <= rd_en;
         if (last_rd)    rd_cnt <= '0;
         else if (rd_en) rd_cnt <= rd_cnt + 1'b1;
         if (handshake) begin
            if (bus.m_last) begin
               out_cnt   <= '0;
               frame_cnt <= frame_cnt + 1'b1;
            end else begin
               out_cnt <= out_cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_fifo_frame_reader.sv
// Directed bench for fifo_frame_reader with FRAME_LEN=8 and a behavioural
// FIFO read port (data appears the cycle after fifo_rd_en).
module tb_fifo_frame_reader;
   localparam int unsigned FL = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] frame_cnt;
   logic        busy;

   fifo_frame_reader_if #(.DATA_WIDTH(16)) bus ();

   fifo_frame_reader #(
      .DATA_WIDTH    (16),
      .FRAME_LEN     (FL),
      .CNT_WIDTH     (16),
      .FRM_CNT_WIDTH (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .bus       (bus),
      .frame_cnt (frame_cnt),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // FIFO model: contents prefilled, wr_ptr controls what is visible
   logic [15:0] mem [0:255];
   int          wr_ptr;
   int          rd_ptr = 0;

   assign bus.fifo_empty = (rd_ptr >= wr_ptr);

   always @(posedge clk) begin
      if (bus.fifo_rd_en) begin
         bus.fifo_rd_data <= mem[rd_ptr];
         rd_ptr           <= rd_ptr + 1;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;
   int exp_ptr  = 0;
   int exp_fcnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        en;
      logic        rdy;
      logic        rd_en;
      logic        valid;
      logic [15:0] data;
      logic        last;
      logic        busy;
      logic [15:0] fcnt;
   } vec_t;

   vec_t vecs [13];

   function automatic vec_t mk(input logic e, input logic r, input logic rd, input logic v,
                               input logic [15:0] d, input logic l, input logic b,
                               input logic [15:0] f);
      vec_t t;
      t.en = e; t.rdy = r; t.rd_en = rd; t.valid = v;
      t.data = d; t.last = l; t.busy = b; t.fcnt = f;
      return t;
   endfunction

   // Streams n_beats, checking order, framing, stall stability and read safety.
   task automatic run_frames(input int n_beats, input int ready_mode, input int en_beats,
                             input int late_cycle, input int late_count, input int max_cycles);
      int          beats = 0;
      int          cyc = 0;
      logic        prev_stall = 1'b0;
      logic [15:0] prev_data = '0;
      while (beats < n_beats && cyc < max_cycles) begin
         en          = (cyc == 0) || (beats < en_beats);
         bus.m_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
         if (cyc == late_cycle) wr_ptr += late_count;
         @(negedge clk);
         if (bus.fifo_empty) check("rd_while_empty", bus.fifo_rd_en, 0);
         check("occ_le_2", dut.u_skid.occ <= 2'd2, 1);
         if (prev_stall) begin
            check("stall_valid", bus.m_valid, 1);
            check("stall_data", bus.m_data, prev_data);
         end
         if (late_cycle >= 0 && cyc == late_cycle - 1) begin
            check("empty_valid_drop", bus.m_valid, 0);
            check("empty_beats", beats, n_beats - late_count);
         end
         if (bus.m_valid && bus.m_ready) begin
            check($sformatf("beat%0d_data", beats), bus.m_data, mem[exp_ptr]);
            check($sformatf("beat%0d_last", beats), bus.m_last, ((beats + 1) % FL) == 0);
            exp_ptr++;
            beats++;
         end
         prev_stall = bus.m_valid && !bus.m_ready;
         prev_data  = bus.m_data;
         @(posedge clk); #1;
         cyc++;
      end
      en = 1'b0;
      check("beats_timeout", beats, n_beats);
   endtask

   task automatic wait_idle(input int max_cycles);
      int c = 0;
      @(negedge clk);
      while (busy && c < max_cycles) begin
         @(negedge clk);
         c++;
      end
      check("idle_timeout", busy, 0);
      check("frame_cnt", frame_cnt, exp_fcnt);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int start;
      for (int i = 0; i < 256; i++)
         mem[i] = (i < 8) ? 16'(16'hFFFF - i) : 16'(16'h4000 + i);
      wr_ptr      = 16;
      rst         = 1'b1;
      en          = 1'b0;
      bus.m_ready = 1'b0;

      vecs[0]  = mk(1, 1, 0, 0, 16'h0000, 0, 0, 0);
      vecs[1]  = mk(0, 1, 1, 0, 16'h0000, 0, 1, 0);
      vecs[2]  = mk(0, 1, 1, 0, 16'h0000, 0, 1, 0);
      vecs[3]  = mk(0, 1, 1, 1, 16'hFFFF, 0, 1, 0);
      vecs[4]  = mk(0, 1, 1, 1, 16'hFFFE, 0, 1, 0);
      vecs[5]  = mk(0, 1, 1, 1, 16'hFFFD, 0, 1, 0);
      vecs[6]  = mk(0, 1, 1, 1, 16'hFFFC, 0, 1, 0);
      vecs[7]  = mk(0, 1, 1, 1, 16'hFFFB, 0, 1, 0);
      vecs[8]  = mk(0, 1, 1, 1, 16'hFFFA, 0, 1, 0);
      vecs[9]  = mk(0, 1, 0, 1, 16'hFFF9, 0, 1, 0);
      vecs[10] = mk(0, 1, 0, 1, 16'hFFF8, 1, 1, 0);
      vecs[11] = mk(0, 1, 0, 0, 16'h0000, 0, 1, 1);
      vecs[12] = mk(0, 1, 0, 0, 16'h0000, 0, 0, 1);

      #200;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle_rd_en", bus.fifo_rd_en, 0);
         check("idle_busy", busy, 0);
         check("idle_valid", bus.m_valid, 0);
         check("idle_data", bus.m_data, 0);
         check("idle_last", bus.m_last, 0);
         check("idle_fcnt", frame_cnt, 0);
      end

      // single frame, cycle-exact
      @(posedge clk); #1;
      for (int i = 0; i < 13; i++) begin
         en          = vecs[i].en;
         bus.m_ready = vecs[i].rdy;
         @(negedge clk);
         check($sformatf("v%0d_rd_en", i), bus.fifo_rd_en, vecs[i].rd_en);
         check($sformatf("v%0d_valid", i), bus.m_valid, vecs[i].valid);
         if (vecs[i].valid) check($sformatf("v%0d_data", i), bus.m_data, vecs[i].data);
         check($sformatf("v%0d_last", i), bus.m_last, vecs[i].last);
         check($sformatf("v%0d_busy", i), busy, vecs[i].busy);
         check($sformatf("v%0d_fcnt", i), frame_cnt, vecs[i].fcnt);
         @(posedge clk); #1;
      end
      check("single_reads", rd_ptr, 8);
      exp_ptr  = 8;
      exp_fcnt = 1;

      // backpressure: ready 1 on / 2 off
      run_frames(8, 1, 0, -1, 0, 100);
      exp_fcnt = 2;
      wait_idle(20);
      check("bp_reads", rd_ptr, 16);

      // FIFO runs dry after 5 samples, remaining 3 arrive later
      wr_ptr += 5;
      run_frames(8, 0, 0, 50, 3, 120);
      exp_fcnt = 3;
      wait_idle(20);
      check("empty_reads", rd_ptr, 24);

      // continuous: en held through 3 frames, dropped inside frame 4
      wr_ptr += 40;
      start = rd_ptr;
      run_frames(32, 0, 28, -1, 0, 100);
      exp_fcnt = 7;
      wait_idle(20);
      check("cont_reads", rd_ptr - start, 32);
      repeat (5) @(posedge clk);
      #1;
      check("cont_no_extra_read", rd_ptr - start, 32);

      // reset mid-frame after beat 3
      wr_ptr += 16;
      run_frames(3, 0, 3, -1, 0, 50);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_rd_en", bus.fifo_rd_en, 0);
      check("rst_valid", bus.m_valid, 0);
      check("rst_data", bus.m_data, 0);
      check("rst_last", bus.m_last, 0);
      check("rst_fcnt", frame_cnt, 0);
      check("rst_busy", busy, 0);
      #10;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      exp_ptr  = rd_ptr;
      exp_fcnt = 1;
      run_frames(8, 0, 1, -1, 0, 60);
      wait_idle(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
